// File: rtl/stream_sum_int_pkg.sv
// Shared primitives for the stream reduction blocks: int width and FSM state encoding.
package stream_sum_int_pkg;

  localparam int unsigned INT_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/beat_down_counter.sv
// Loadable down-counter of stream beats; saturates at zero and flags the last beat.
module beat_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  // Load wins over decrement; decrement at zero is ignored so the count never wraps.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != W'(0))) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/stream_sum_int.sv
// Reads dCount beats from an upstream stream and returns their wrapped N-bit sum.
module stream_sum_int
  import stream_sum_int_pkg::*;
#(
  parameter int unsigned N = INT_N
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dCount,
  input  logic [N-1:0] sIn,
  input  logic         sIn_valid,
  output logic         sIn_ready,
  output logic [N-1:0] dOut,
  output logic         out_valid,
  input  logic         out_ready
);

  state_e       state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic         in_ready_q, sin_ready_q, out_valid_q;
  logic         cnt_load, cnt_dec, cnt_last;

  beat_down_counter #(.W(N)) u_remaining (
    .clk        (clk),
    .nrst       (nrst),
    .load_i     (cnt_load),
    .load_val_i (dCount),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  // Next-state, accumulator and counter control.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cnt_load = 1'b1;
          acc_d    = '0;
          state_d  = (dCount == N'(0)) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (sIn_valid) begin
          cnt_dec = 1'b1;
          acc_d   = acc_q + sIn;
          if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      sin_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      in_ready_q  <= (state_d == ST_IDLE);
      sin_ready_q <= (state_d == ST_READ);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign sIn_ready = sin_ready_q;
  assign out_valid = out_valid_q;
  assign dOut      = acc_q;

endmodule

// File: tb/tb_stream_sum_int.sv
// Scoreboard bench for stream_sum_int: directed requests, monitor checks each result handshake.
module tb_stream_sum_int;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         nrst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dCount;
  logic [N-1:0] sIn;
  logic         sIn_valid;
  logic         sIn_ready;
  logic [N-1:0] dOut;
  logic         out_valid;
  logic         out_ready;

  int           tests = 0;
  int           fails = 0;
  int           beats = 0;
  logic [N-1:0] sb[$];

  stream_sum_int #(.N(N)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dCount    (dCount),
    .sIn       (sIn),
    .sIn_valid (sIn_valid),
    .sIn_ready (sIn_ready),
    .dOut      (dOut),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Count consumed beats using values stable since the previous falling edge.
  always @(posedge clk) begin
    if (nrst && sIn_valid && sIn_ready) beats <= beats + 1;
  end

  // Monitor: every result handshake pops and compares one expected sum.
  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("result_sum", int'(dOut), int'(sb.pop_front()));
      end
    end
  end

  task automatic request(input logic [N-1:0] cnt);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("req_timeout", 0, 1);
    in_valid = 1'b1;
    dCount   = cnt;
    @(negedge clk);
    in_valid = 1'b0;
    dCount   = 'x;
  endtask

  task automatic send_beat(input logic [N-1:0] v, input int gap);
    int t = 0;
    sIn_valid = 1'b1;
    sIn       = v;
    while (!sIn_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!sIn_ready) check("beat_timeout", 0, 1);
    @(negedge clk);
    sIn_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_result();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check("result_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    nrst      = 1'b0;
    in_valid  = 1'b0;
    dCount    = '0;
    sIn       = '0;
    sIn_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_sin_ready", int'(sIn_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout", int'(dOut), 0);
    nrst = 1'b1;
    @(negedge clk);

    // Basic sum 5+7+9
    beats = 0;
    request(8'd3);
    sb.push_back(8'd21);
    send_beat(8'd5, 0);
    send_beat(8'd7, 0);
    send_beat(8'd9, 0);
    check("basic_latency_out_valid", int'(out_valid), 1);
    wait_result();
    check("basic_beats", beats, 3);
    check("basic_out_valid_drop", int'(out_valid), 0);
    check("basic_idle_in_ready", int'(in_ready), 1);

    // Zero count with an eager upstream
    beats     = 0;
    sIn       = 8'd77;
    sIn_valid = 1'b1;
    request(8'd0);
    check("zero_latency_out_valid", int'(out_valid), 1);
    check("zero_sin_ready", int'(sIn_ready), 0);
    sb.push_back(8'd0);
    wait_result();
    check("zero_beats", beats, 0);
    sIn_valid = 1'b0;

    // Wrap-around with bubbles: 200+100+0+1 = 301 mod 256
    beats = 0;
    request(8'd4);
    sb.push_back(8'd45);
    send_beat(8'd200, 2);
    send_beat(8'd100, 2);
    send_beat(8'd0, 2);
    send_beat(8'd1, 0);
    wait_result();
    check("wrap_beats", beats, 4);

    // Result backpressure with extra upstream data offered
    beats     = 0;
    out_ready = 1'b0;
    request(8'd1);
    sb.push_back(8'd42);
    send_beat(8'd42, 0);
    sIn_valid = 1'b1;
    sIn       = 8'd99;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_dout", int'(dOut), 42);
      check("bp_sin_ready", int'(sIn_ready), 0);
      check("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    sIn_valid = 1'b0;
    out_ready = 1'b1;
    wait_result();
    check("bp_beats", beats, 1);
    check("bp_idle_in_ready", int'(in_ready), 1);

    // Chained behind a constant repeat source of 42
    beats     = 0;
    sIn       = 8'd42;
    sIn_valid = 1'b1;
    request(8'd2);
    sb.push_back(8'd84);
    wait_result();
    check("chain_beats", beats, 2);
    check("chain_sin_ready_idle", int'(sIn_ready), 0);
    sIn_valid = 1'b0;

    // Asynchronous reset mid-read
    request(8'd5);
    send_beat(8'd10, 0);
    send_beat(8'd20, 0);
    #2 nrst = 1'b0;
    #1;
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_sin_ready", int'(sIn_ready), 0);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_dout", int'(dOut), 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    request(8'd1);
    sb.push_back(8'd3);
    send_beat(8'd3, 0);
    wait_result();
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
